// File: rtl/kernel_window.sv
// KERNEL_SIZE x KERNEL_SIZE neighbourhood generator with runtime bypass, column-overflow guard and header rewrite.
// Optional feature: define KERNEL_WINDOW_COORD_EN to add row_o/col_o output-image coordinates.
module kernel_window #(
  parameter int KERNEL_SIZE    = 3,
  parameter int PIXEL_WIDTH    = 10,
  parameter int DATA_WIDTH     = 16,
  parameter int MAX_COLS       = 1288,
  parameter int NUM_COLS_WIDTH = 11,
  parameter int DTYPE_WIDTH    = 8,
  parameter logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START  = 'h01,
  parameter logic [DTYPE_WIDTH-1:0] DTYPE_ROW_START    = 'h04,
  parameter logic [DTYPE_WIDTH-1:0] DTYPE_ROW_END      = 'h08,
  parameter logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL_MASK   = 'h10,
  parameter logic [DTYPE_WIDTH-1:0] DTYPE_HEADER_START = 'h20,
  parameter logic [DTYPE_WIDTH-1:0] DTYPE_HEADER       = 'h40,
  parameter int HDR_ADDR_WIDTH    = 8,
  parameter int HDR_NUM_COLS_ADDR = 0,
  parameter int HDR_NUM_ROWS_ADDR = 1
) (
  input  logic                                         clk,
  input  logic                                         resetb,
  input  logic                                         enable,
  input  logic                                         dvi,
  input  logic [DTYPE_WIDTH-1:0]                       dtypei,
  input  logic [DATA_WIDTH-1:0]                        datai,
  output logic                                         dvo,
  output logic [DTYPE_WIDTH-1:0]                       dtypeo,
  output logic [DATA_WIDTH-1:0]                        meta_datao,
  output logic [KERNEL_SIZE*KERNEL_SIZE*PIXEL_WIDTH-1:0] kernel_datao,
  output logic                                         col_overflow
`ifdef KERNEL_WINDOW_COORD_EN
  ,
  output logic [NUM_COLS_WIDTH-1:0]                    row_o,
  output logic [NUM_COLS_WIDTH-1:0]                    col_o
`endif
);

  localparam int NB         = KERNEL_SIZE - 1;
  localparam int PTR_W      = $clog2(NB);
  localparam int ROW_W      = $clog2(KERNEL_SIZE);
  localparam int KERN_W     = KERNEL_SIZE * KERNEL_SIZE * PIXEL_WIDTH;
  localparam int CENTRE_LSB = ((KERNEL_SIZE / 2) * KERNEL_SIZE + KERNEL_SIZE / 2) * PIXEL_WIDTH;

  logic                      mode_q;
  logic [ROW_W-1:0]          row_cnt;
  logic [NUM_COLS_WIDTH-1:0] col_cnt;
  logic                      col_full;
  logic [PTR_W-1:0]          wr_ptr;
  logic [HDR_ADDR_WIDTH-1:0] header_addr;
  logic [DATA_WIDTH-1:0]     meta_next;

  logic [PIXEL_WIDTH-1:0] rowbuf [NB][MAX_COLS];
  logic [PIXEL_WIDTH-1:0] col_in [KERNEL_SIZE];

  logic is_frame_start, is_row_start, is_row_end, is_pixel, is_header_start, is_header;
  logic row_valid, col_edge, col_last;

  assign is_frame_start  = (dtypei == DTYPE_FRAME_START);
  assign is_row_start    = (dtypei == DTYPE_ROW_START);
  assign is_row_end      = (dtypei == DTYPE_ROW_END);
  assign is_pixel        = (|(dtypei & DTYPE_PIXEL_MASK)) && !is_frame_start && !is_row_start && !is_row_end;
  assign is_header_start = (dtypei == DTYPE_HEADER_START);
  assign is_header       = (dtypei == DTYPE_HEADER);

  assign row_valid = (row_cnt >= ROW_W'(NB));
  assign col_edge  = (col_cnt >= NUM_COLS_WIDTH'(NB));
  assign col_last  = (col_cnt == NUM_COLS_WIDTH'(MAX_COLS - 1));

  // Row r of the new kernel column comes from the buffer wr_ptr+r steps ahead (oldest first).
  for (genvar r = 0; r < NB; r++) begin : g_rd
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] sel;
    assign sum       = {1'b0, wr_ptr} + (PTR_W+1)'(r);
    assign sel       = (sum >= (PTR_W+1)'(NB)) ? PTR_W'(sum - (PTR_W+1)'(NB)) : sum[PTR_W-1:0];
    assign col_in[r] = rowbuf[sel][col_cnt];
  end
  assign col_in[NB] = datai[PIXEL_WIDTH-1:0];

  always_comb begin
    meta_next = datai;
    if (mode_q && is_header &&
        (header_addr == HDR_ADDR_WIDTH'(HDR_NUM_COLS_ADDR) ||
         header_addr == HDR_ADDR_WIDTH'(HDR_NUM_ROWS_ADDR)))
      meta_next = datai - DATA_WIDTH'(NB);
  end

  always_ff @(posedge clk) begin
    if (dvi && is_pixel && mode_q && !col_full)
      rowbuf[wr_ptr][col_cnt] <= datai[PIXEL_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      dvo          <= 1'b0;
      dtypeo       <= '0;
      meta_datao   <= '0;
      kernel_datao <= '0;
      col_overflow <= 1'b0;
      mode_q       <= 1'b0;
      row_cnt      <= '0;
      col_cnt      <= '0;
      col_full     <= 1'b0;
      wr_ptr       <= '0;
      header_addr  <= '0;
    end else if (!dvi) begin
      dvo <= 1'b0;
    end else begin
      dtypeo     <= dtypei;
      meta_datao <= meta_next;
      dvo        <= 1'b1;
      if (is_frame_start) begin
        mode_q       <= enable;
        row_cnt      <= '0;
        wr_ptr       <= '0;
        col_cnt      <= '0;
        col_full     <= 1'b0;
        col_overflow <= 1'b0;
      end else if (is_row_start) begin
        col_cnt  <= '0;
        col_full <= 1'b0;
        dvo      <= !mode_q || row_valid;
      end else if (is_row_end) begin
        wr_ptr <= (wr_ptr == PTR_W'(NB - 1)) ? '0 : wr_ptr + 1'b1;
        if (!row_valid) row_cnt <= row_cnt + 1'b1;
        dvo <= !mode_q || row_valid;
      end else if (is_pixel) begin
        if (!mode_q) kernel_datao <= KERN_W'(datai[PIXEL_WIDTH-1:0]) << CENTRE_LSB;
        // Once the last column is consumed, further pixels of the row are dropped.
        if (col_full) begin
          col_overflow <= 1'b1;
          dvo          <= !mode_q;
        end else begin
          if (!col_last) col_cnt <= col_cnt + 1'b1;
          col_full <= col_last;
          if (mode_q) begin
            for (int r = 0; r < KERNEL_SIZE; r++) begin
              for (int c = 0; c < KERNEL_SIZE - 1; c++)
                kernel_datao[(r*KERNEL_SIZE+c)*PIXEL_WIDTH +: PIXEL_WIDTH] <=
                  kernel_datao[(r*KERNEL_SIZE+c+1)*PIXEL_WIDTH +: PIXEL_WIDTH];
              kernel_datao[(r*KERNEL_SIZE+KERNEL_SIZE-1)*PIXEL_WIDTH +: PIXEL_WIDTH] <= col_in[r];
            end
            dvo <= row_valid && col_edge;
          end
        end
      end else if (is_header_start) begin
        header_addr <= '0;
      end else if (is_header) begin
        header_addr <= header_addr + 1'b1;
      end
    end
  end

`ifdef KERNEL_WINDOW_COORD_EN
  // Raw (non-saturating) row index, used only for the coordinate outputs.
  logic [NUM_COLS_WIDTH-1:0] row_cnt_out;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      row_cnt_out <= '0;
      row_o       <= '0;
      col_o       <= '0;
    end else if (dvi) begin
      if (is_frame_start) begin
        row_cnt_out <= '0;
        row_o       <= '0;
        col_o       <= '0;
      end else if (is_row_start) begin
        row_o <= '0;
        col_o <= '0;
      end else if (is_row_end) begin
        row_cnt_out <= row_cnt_out + 1'b1;
      end else if (is_pixel && !col_full) begin
        row_o <= mode_q ? row_cnt_out - NUM_COLS_WIDTH'(NB) : row_cnt_out;
        col_o <= mode_q ? col_cnt - NUM_COLS_WIDTH'(NB) : col_cnt;
      end
    end
  end
`else
  // No coordinate tracking in this build.
`endif

endmodule

// File: tb/tb_kernel_window.sv
// Scoreboard bench for kernel_window (K=3, MAX_COLS=16): kernel, bypass, gaps, overflow, enable toggle, reset.
module tb_kernel_window;
  localparam int K = 3, PW = 10, DW = 16, MAXC = 16, NCW = 4, DTW = 8;
  localparam int NB = K - 1, KW = K * K * PW;
  localparam logic [DTW-1:0] FS = 8'h01, FE = 8'h02, RS = 8'h04, RE = 8'h08;
  localparam logic [DTW-1:0] PIX = 8'h10, HS = 8'h20, HD = 8'h40;

  logic clk, resetb, enable, dvi, dvo, col_overflow;
  logic [DTW-1:0] dtypei, dtypeo;
  logic [DW-1:0]  datai, meta_datao;
  logic [KW-1:0]  kernel_datao;
`ifdef KERNEL_WINDOW_COORD_EN
  logic [NCW-1:0] row_o, col_o;
`endif

  kernel_window #(
    .KERNEL_SIZE(K), .PIXEL_WIDTH(PW), .DATA_WIDTH(DW), .MAX_COLS(MAXC), .NUM_COLS_WIDTH(NCW),
    .DTYPE_WIDTH(DTW), .DTYPE_FRAME_START(FS), .DTYPE_ROW_START(RS), .DTYPE_ROW_END(RE),
    .DTYPE_PIXEL_MASK(PIX), .DTYPE_HEADER_START(HS), .DTYPE_HEADER(HD),
    .HDR_ADDR_WIDTH(8), .HDR_NUM_COLS_ADDR(0), .HDR_NUM_ROWS_ADDR(1)
  ) dut (
    .clk(clk), .resetb(resetb), .enable(enable), .dvi(dvi), .dtypei(dtypei), .datai(datai),
    .dvo(dvo), .dtypeo(dtypeo), .meta_datao(meta_datao), .kernel_datao(kernel_datao),
    .col_overflow(col_overflow)
`ifdef KERNEL_WINDOW_COORD_EN
    , .row_o(row_o), .col_o(col_o)
`endif
  );

  typedef struct {
    logic [DTW-1:0] dtype;
    logic [DW-1:0]  meta;
    logic [KW-1:0]  kern;
    bit             chk;
    int             row;
    int             col;
  } exp_t;

  typedef struct {
    bit en;
    int nrows;
    int ncols;
    int fill;
    int gap;
    bit toggle;
    int expPix;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[6];
  logic [PW-1:0] frameMem [12][24];
  int checks = 0, failures = 0, pixCount = 0, gapPct = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [DTW-1:0] dt, input logic [DW-1:0] d);
    int gaps;
    gaps = 0;
    while (gapPct > 0 && int'($urandom_range(99)) < gapPct && gaps < 8) begin
      @(negedge clk);
      dvi = 1'b0; dtypei = DTW'($urandom); datai = DW'($urandom);
      gaps++;
    end
    @(negedge clk);
    dvi = 1'b1; dtypei = dt; datai = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      dvi = 1'b0;
    end
  endtask

  task automatic pushExp(input logic [DTW-1:0] dt, input logic [DW-1:0] m, input logic [KW-1:0] k,
                         input bit chk, input int row, input int col);
    exp_t e;
    e.dtype = dt; e.meta = m; e.kern = k; e.chk = chk; e.row = row; e.col = col;
    sbq.push_back(e);
  endtask

  function automatic logic [KW-1:0] modelKernel(input int row, input int col);
    logic [KW-1:0] k;
    k = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        k[((r*K)+c)*PW +: PW] = frameMem[row-NB+r][col-NB+c];
    return k;
  endfunction

  function automatic logic [KW-1:0] bypassKernel(input logic [PW-1:0] p);
    logic [KW-1:0] k;
    k = '0;
    k[((K/2)*K + K/2)*PW +: PW] = p;
    return k;
  endfunction

  // Drives one frame and queues every output the golden model expects; stopRow>=0 aborts mid-row.
  task automatic sendFrame(input bit en, input int nrows, input int ncols, input bit toggle, input int stopRow);
    logic [PW-1:0] pix;
    enable = en;
    applyStimulus(FS, '0);
    pushExp(FS, '0, '0, 0, 0, 0);
    @(posedge clk); #1;
    checkOutput("col_overflow cleared at frame start", col_overflow, 0);
    applyStimulus(HS, '0);                 pushExp(HS, '0, '0, 0, 0, 0);
    applyStimulus(HD, DW'(ncols));         pushExp(HD, DW'(en ? ncols - NB : ncols), '0, 0, 0, 0);
    applyStimulus(HD, DW'(nrows));         pushExp(HD, DW'(en ? nrows - NB : nrows), '0, 0, 0, 0);
    applyStimulus(HD, 16'h0055);           pushExp(HD, 16'h0055, '0, 0, 0, 0);
    for (int r = 0; r < nrows; r++) begin
      if (toggle && r == 2) enable = ~en;
      applyStimulus(RS, '0);
      if (!en || r >= NB) pushExp(RS, '0, '0, 0, 0, 0);
      for (int c = 0; c < ncols; c++) begin
        if (r == stopRow && c == ncols / 2) return;
        pix = frameMem[r][c];
        applyStimulus(PIX, DW'(pix));
        if (!en) pushExp(PIX, DW'(pix), bypassKernel(pix), 1, r, c);
        else if (r >= NB && c >= NB && c < MAXC) pushExp(PIX, DW'(pix), modelKernel(r, c), 1, r - NB, c - NB);
        if (en && ncols > MAXC && r == 0 && (c == MAXC - 1 || c == MAXC)) begin
          @(posedge clk); #1;
          checkOutput(c == MAXC ? "col_overflow after 17th pixel" : "col_overflow after 16th pixel",
                      col_overflow, (c == MAXC) ? 1 : 0);
        end
      end
      applyStimulus(RE, '0);
      if (!en || r >= NB) pushExp(RE, '0, '0, 0, 0, 0);
    end
    applyStimulus(FE, '0);
    pushExp(FE, '0, '0, 0, 0, 0);
    idle(3);
    checkOutput("scoreboard drained", sbq.size(), 0);
  endtask

  task automatic checkReset();
    checkOutput("reset dvo", dvo, 0);
    checkOutput("reset dtypeo", dtypeo, 0);
    checkOutput("reset meta_datao", meta_datao, 0);
    checkOutput("reset kernel_datao", kernel_datao, 0);
    checkOutput("reset col_overflow", col_overflow, 0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (resetb === 1'b1 && dvo === 1'b1) begin
      if (dtypeo == PIX) pixCount++;
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected dvo: got dtypeo 0x%0h meta 0x%0h expected no output", dtypeo, meta_datao);
      end else begin
        e = sbq.pop_front();
        checkOutput("dtypeo", dtypeo, e.dtype);
        checkOutput("meta_datao", meta_datao, e.meta);
        if (e.chk) checkOutput("kernel_datao", kernel_datao, e.kern);
`ifdef KERNEL_WINDOW_COORD_EN
        if (e.chk) begin
          checkOutput("row_o", row_o, NCW'(e.row));
          checkOutput("col_o", col_o, NCW'(e.col));
        end
`endif
      end
    end
  end

  initial begin
    resetb = 1'b0; enable = 1'b0; dvi = 1'b0; dtypei = '0; datai = '0;
    vecs[0] = '{en: 1, nrows: 6,  ncols: 8,  fill: 1, gap: 0,  toggle: 0, expPix: 24};
    vecs[1] = '{en: 0, nrows: 6,  ncols: 8,  fill: 0, gap: 0,  toggle: 0, expPix: 48};
    vecs[2] = '{en: 1, nrows: 10, ncols: 10, fill: 2, gap: 0,  toggle: 0, expPix: 64};
    vecs[3] = '{en: 1, nrows: 10, ncols: 10, fill: 0, gap: 50, toggle: 0, expPix: 64};
    vecs[4] = '{en: 1, nrows: 4,  ncols: 20, fill: 1, gap: 0,  toggle: 0, expPix: 28};
    vecs[5] = '{en: 1, nrows: 6,  ncols: 8,  fill: 1, gap: 0,  toggle: 1, expPix: 24};
    repeat (3) @(negedge clk);
    checkReset();
    resetb = 1'b1;
    idle(2);

    for (int i = 0; i < 6; i++) begin
      for (int r = 0; r < 12; r++)
        for (int c = 0; c < 24; c++)
          if (vecs[i].fill == 1) frameMem[r][c] = PW'(r * 16 + c);
          else if (vecs[i].fill == 2) frameMem[r][c] = PW'($urandom_range(1023));
      gapPct = vecs[i].gap;
      pixCount = 0;
      $display("[TB] frame %0d: en=%0d %0dx%0d gap=%0d%%", i, vecs[i].en, vecs[i].ncols, vecs[i].nrows, vecs[i].gap);
      sendFrame(vecs[i].en, vecs[i].nrows, vecs[i].ncols, vecs[i].toggle, -1);
      checkOutput("pixel output count", pixCount, vecs[i].expPix);
    end

    // Reset pulsed mid-row, then a clean frame must match the model despite stale row buffers.
    gapPct = 0;
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 24; c++)
        frameMem[r][c] = PW'(r * 16 + c + 3);
    sendFrame(1'b1, 6, 8, 1'b0, 3);
    idle(2);
    checkOutput("scoreboard drained before reset", sbq.size(), 0);
    resetb = 1'b0;
    #1;
    checkReset();
    idle(2);
    resetb = 1'b1;
    idle(1);
    pixCount = 0;
    sendFrame(1'b1, 6, 8, 1'b0, -1);
    checkOutput("pixel output count after reset", pixCount, 24);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
